// File: rtl/boron_pkg.sv
// Shared definitions for the boron key schedule: S-boxes, rotation,
// round-constant width and FSM state encoding.
package boron_pkg;

    localparam int RC_W    = 5;
    localparam int ROT_AMT = 13;

    localparam logic [3:0] SBOX [16] = '{
        4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
        4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'hA, 4'h3, 4'h9, 4'hE, 4'h1, 4'hD, 4'hF, 4'h4,
        4'hC, 4'h5, 4'h7, 4'h2, 4'h6, 4'h8, 4'h0, 4'hB
    };

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_PRECOMP = 2'd1;
    localparam state_t ST_EMIT    = 2'd2;
    localparam state_t ST_FIN     = 2'd3;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        return SBOX_INV[x];
    endfunction

endpackage

// File: rtl/boron_key_sched_unit_if.sv
// Round-key output channel: valid/ready handshake with key and index.
interface boron_key_sched_unit_if;
    import boron_pkg::*;

    logic            rk_valid;
    logic            rk_ready;
    logic [63:0]     rk;
    logic [RC_W-1:0] rk_idx;

    modport master (
        output rk_valid,
        output rk,
        output rk_idx,
        input  rk_ready
    );

    modport slave (
        input  rk_valid,
        input  rk,
        input  rk_idx,
        output rk_ready
    );

endinterface

// File: rtl/boron_ks_round.sv
// One key-schedule step: forward update F or its exact inverse G.
module boron_ks_round
    import boron_pkg::*;
#(
    parameter int KEY_W = 80
) (
    input  logic             inv,
    input  logic [RC_W-1:0]  rc,
    input  logic [KEY_W-1:0] k_in,
    output logic [KEY_W-1:0] k_out
);

    logic [KEY_W-1:0] rot_l;
    logic [KEY_W-1:0] fwd;
    logic [KEY_W-1:0] pre_r;
    logic [KEY_W-1:0] bwd;

    always_comb begin
        rot_l = {k_in[KEY_W-ROT_AMT-1:0], k_in[KEY_W-1:KEY_W-ROT_AMT]};
        fwd = rot_l;
        fwd[3:0] = sbox(rot_l[3:0]);
        if (KEY_W == 128) begin
            fwd[7:4] = sbox(rot_l[7:4]);
        end
        fwd[63:59] = rot_l[63:59] ^ rc;
    end

    // Undo F in reverse order: constant, S-box, then rotation.
    always_comb begin
        pre_r = k_in;
        pre_r[63:59] = k_in[63:59] ^ rc;
        pre_r[3:0] = sbox_inv(k_in[3:0]);
        if (KEY_W == 128) begin
            pre_r[7:4] = sbox_inv(k_in[7:4]);
        end
        bwd = {pre_r[ROT_AMT-1:0], pre_r[KEY_W-1:ROT_AMT]};
    end

    assign k_out = inv ? bwd : fwd;

endmodule

// File: rtl/boron_key_sched_unit.sv
// Round-key scheduler: emits ROUNDS+1 keys in encrypt or decrypt order
// over a valid/ready channel, precomputing the final key for decrypt.
module boron_key_sched_unit
    import boron_pkg::*;
#(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [KEY_W-1:0]      key_in,
    output logic                  busy,
    output logic                  done,
    boron_key_sched_unit_if.master rk_if
);

    localparam logic [RC_W-1:0] LAST_IDX = RC_W'(ROUNDS);

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [RC_W-1:0]  idx_q, idx_d;
    logic             mode_q, mode_d;

    logic             rnd_inv;
    logic [RC_W-1:0]  rnd_rc;
    logic [KEY_W-1:0] rnd_key;
    logic             xfer;
    logic             at_end;

    boron_ks_round #(
        .KEY_W (KEY_W)
    ) u_round (
        .inv   (rnd_inv),
        .rc    (rnd_rc),
        .k_in  (key_q),
        .k_out (rnd_key)
    );

    // Decrypt steps back with c = idx; every other step uses c = idx+1.
    always_comb begin
        rnd_inv = (state_q == ST_EMIT) && mode_q;
        rnd_rc  = rnd_inv ? idx_q : idx_q + 1'b1;
        xfer    = (state_q == ST_EMIT) && rk_if.rk_ready;
        at_end  = mode_q ? (idx_q == '0) : (idx_q == LAST_IDX);
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    idx_d   = '0;
                    mode_d  = mode;
                    state_d = mode ? ST_PRECOMP : ST_EMIT;
                end
            end
            ST_PRECOMP: begin
                key_d = rnd_key;
                idx_d = idx_q + 1'b1;
                if (idx_q + 1'b1 == LAST_IDX) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (xfer) begin
                    if (at_end) begin
                        state_d = ST_FIN;
                    end else begin
                        key_d = rnd_key;
                        idx_d = mode_q ? idx_q - 1'b1 : idx_q + 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_FIN);
    assign rk_if.rk_valid = (state_q == ST_EMIT);
    assign rk_if.rk       = key_q[63:0];
    assign rk_if.rk_idx   = idx_q;

endmodule

// File: tb/tb_boron_key_sched_unit.sv
// Scoreboard bench for boron_key_sched_unit at KEY_W=80 and KEY_W=128.
module tb_boron_key_sched_unit;

    typedef struct {
        bit          d;
        logic [63:0] k;
        logic [4:0]  i;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         st_a, md_a, bz_a, dn_a;
    logic [79:0]  key_a;
    logic         st_b, md_b, bz_b, dn_b;
    logic [127:0] key_b;
    logic         rdy;
    logic         rand_en  = 1'b0;
    logic         hold_rdy = 1'b1;

    boron_key_sched_unit_if if_a ();
    boron_key_sched_unit_if if_b ();
    assign if_a.rk_ready = rdy;
    assign if_b.rk_ready = rdy;

    boron_key_sched_unit #(.KEY_W(80), .ROUNDS(25)) u_a (
        .clk(clk), .rst(rst), .start(st_a), .mode(md_a), .key_in(key_a),
        .busy(bz_a), .done(dn_a), .rk_if(if_a)
    );

    boron_key_sched_unit #(.KEY_W(128), .ROUNDS(25)) u_b (
        .clk(clk), .rst(rst), .start(st_b), .mode(md_b), .key_in(key_b),
        .busy(bz_b), .done(dn_b), .rk_if(if_b)
    );

    exp_t         sbq[$];
    bit           done_exp[2];
    int           n_chk = 0;
    int           n_pass = 0;
    logic [127:0] ks[26];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [3:0] sb(input logic [3:0] x);
        case (x)
            4'h0: return 4'hE; 4'h1: return 4'h4; 4'h2: return 4'hB; 4'h3: return 4'h1;
            4'h4: return 4'h7; 4'h5: return 4'h9; 4'h6: return 4'hC; 4'h7: return 4'hA;
            4'h8: return 4'hD; 4'h9: return 4'h2; 4'hA: return 4'h0; 4'hB: return 4'hF;
            4'hC: return 4'h8; 4'hD: return 4'h5; 4'hE: return 4'h3; default: return 4'h6;
        endcase
    endfunction

    function automatic logic [127:0] mf(input logic [127:0] k, input int w,
                                        input logic [4:0] c);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < w; j++) r[(j + 13) % w] = k[j];
        r[3:0] = sb(r[3:0]);
        if (w == 128) r[7:4] = sb(r[7:4]);
        r[63:59] = r[63:59] ^ c;
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic gen(input int w, input logic [127:0] k0);
        logic [127:0] m;
        m = (w == 128) ? {128{1'b1}} : {48'h0, {80{1'b1}}};
        ks[0] = k0 & m;
        for (int i = 0; i < 25; i++) ks[i+1] = mf(ks[i], w, 5'(i + 1));
    endtask

    task automatic push(input int d, input bit m, input bit hand, input int cnt);
        exp_t e;
        int   i;
        for (int j = 0; j < cnt; j++) begin
            i = m ? 25 - j : j;
            e.d = (d != 0);
            e.i = 5'(i);
            e.k = ks[i][63:0];
            e.last = (j == 25);
            if (hand && i == 0) e.k = 64'h0;
            if (hand && i == 1) e.k = 64'h080000000000000E;
            if (hand && i == 2) e.k = 64'h100000000001C00E;
            sbq.push_back(e);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic r,
                       input logic [63:0] k, input logic [4:0] i, input logic dn);
        exp_t e;
        bit   ok;
        if (dn || done_exp[d]) begin
            chk($sformatf("done%0d", d), 128'(dn), 128'(done_exp[d]));
            done_exp[d] = 0;
        end
        if (v) begin
            ok = sbq.size() != 0 && sbq[0].d == (d != 0);
            chk($sformatf("key_expected%0d idx=%0d", d, i), 128'(ok), 128'(1));
            if (ok) begin
                e = sbq[0];
                chk($sformatf("rk%0d idx=%0d", d, e.i), 128'(k), 128'(e.k));
                chk($sformatf("rk_idx%0d", d), 128'(i), 128'(e.i));
                if (r) begin
                    void'(sbq.pop_front());
                    if (e.last) done_exp[d] = 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, if_a.rk_valid, if_a.rk_ready, if_a.rk, if_a.rk_idx, dn_a);
        mon(1, if_b.rk_valid, if_b.rk_ready, if_b.rk, if_b.rk_idx, dn_b);
    end

    initial begin
        rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            rdy = rand_en ? 1'($urandom_range(0, 1)) : hold_rdy;
        end
    end

    task automatic zero_chk(input string nm);
        chk({nm, "_busy"}, 128'(bz_a), 128'(0));
        chk({nm, "_valid"}, 128'(if_a.rk_valid), 128'(0));
        chk({nm, "_done"}, 128'(dn_a), 128'(0));
        chk({nm, "_rk"}, 128'(if_a.rk), 128'(0));
        chk({nm, "_idx"}, 128'(if_a.rk_idx), 128'(0));
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 128'(sbq.size()), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 128'(d != 0 ? bz_b : bz_a), 128'(0));
    endtask

    task automatic run_sched(input int d, input bit m, input logic [127:0] key,
                             input bit hand);
        int n;
        gen(d != 0 ? 128 : 80, key);
        push(d, m, hand, 26);
        @(posedge clk); #1;
        if (d != 0) begin st_b = 1; md_b = m; key_b = key; end
        else begin st_a = 1; md_a = m; key_a = key[79:0]; end
        @(posedge clk); #1;
        st_a = 0; st_b = 0; md_a = ~m; md_b = ~m;
        key_a = 80'(rnd128()); key_b = rnd128();
        n = 1;
        while (!(d != 0 ? if_b.rk_valid : if_a.rk_valid) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("latency d%0d m%0d", d, m), 128'(n), 128'(m ? 26 : 1));
        drain(d);
    endtask

    task automatic rst_test();
        int n;
        @(posedge clk); #1;
        st_a = 1; rst = 1;
        @(posedge clk); #1;
        st_a = 0; rst = 0;
        zero_chk("rst_over_start");
        st_a = 1; md_a = 1; key_a = 80'(rnd128());
        @(posedge clk); #1;
        st_a = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("precomp_state", 128'({bz_a, if_a.rk_valid}), 128'(2'b10));
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        zero_chk("rst_precomp");
        gen(80, 128'(key_a));
        push(0, 0, 0, 8);
        md_a = 0; st_a = 1;
        @(posedge clk); #1;
        st_a = 0;
        n = 0;
        while (if_a.rk_idx != 5'd7 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_idx7", 128'(if_a.rk_idx), 128'(7));
        hold_rdy = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        zero_chk("rst_emit");
        sbq.delete();
        hold_rdy = 1;
        repeat (4) @(posedge clk);
    endtask

    task automatic held_test();
        logic [127:0] ka, kb;
        int n;
        ka = rnd128(); kb = rnd128();
        gen(80, ka); push(0, 0, 0, 26);
        gen(80, kb); push(0, 0, 0, 26);
        @(posedge clk); #1;
        st_a = 1; md_a = 0; key_a = ka[79:0];
        @(posedge clk); #1;
        md_a = 1; key_a = kb[79:0];
        n = 0;
        while (!dn_a && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_first_done", 128'(dn_a), 128'(1));
        md_a = 0;
        @(posedge clk);
        @(posedge clk); #1;
        st_a = 0;
        drain(0);
        repeat (40) @(posedge clk);
        #1;
        chk("held_no_third", 128'({bz_a, if_a.rk_valid}), 128'(0));
    endtask

    initial begin
        logic [127:0] k;
        rst = 1; st_a = 0; md_a = 0; key_a = '0; st_b = 0; md_b = 0; key_b = '0;
        repeat (3) @(posedge clk);
        #1;
        zero_chk("reset");
        chk("reset_b", 128'({bz_b, if_b.rk_valid, dn_b, if_b.rk, if_b.rk_idx}), 128'(0));
        rst = 0;
        run_sched(0, 0, '0, 1);
        run_sched(0, 1, '0, 1);
        rand_en = 1;
        k = rnd128();
        run_sched(0, 0, k, 0);
        run_sched(0, 1, k, 0);
        k = rnd128();
        run_sched(1, 0, k, 0);
        run_sched(1, 1, k, 0);
        rand_en = 0;
        k = rnd128();
        run_sched(1, 0, k, 0);
        run_sched(1, 1, k, 0);
        rst_test();
        run_sched(0, 0, '0, 1);
        held_test();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/boron_key_sched_unit.md
BORON_KEY_SCHED_UNIT -- requirements
Module: boron_key_sched_unit

Interface
REQ-001 Parameter KEY_W, default 80, master key width; legal values 80 and 128 only.
REQ-002 Parameter ROUNDS, default 25, number of cipher rounds; legal range 1..31.
REQ-003 Parameter RC_W, default 5, round-constant width; fixed by the package, not overridable.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a schedule; sampled only in IDLE.
REQ-007 mode  input  1  0 = encrypt order, 1 = decrypt order; sampled with start.
REQ-008 key_in  input  KEY_W  master key; sampled with start.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 rk_valid  output  1  round key present on rk.
REQ-011 rk_ready  input  1  consumer accepts rk; a transfer occurs when rk_valid and rk_ready are both high.
REQ-012 rk  output  64  current round key, equal to the key register bits [63:0].
REQ-013 rk_idx  output  5  round index i of the key on rk.
REQ-014 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-015 The forward update F(K, c) SHALL be:
- rotate K left by 13;
- S-box nibble [3:0], and also nibble [7:4] when KEY_W = 128;
- XOR c into bits [63:59].
REQ-016 The inverse update G(K, c) SHALL be the exact inverse of F: XOR c into [63:59], inverse S-box on the same nibble(s), then rotate right by 13.
REQ-017 Key sequence: K_0 = key_in; K_(i+1) = F(K_i, i+1) for i = 0..ROUNDS-1; a schedule emits ROUNDS+1 keys.
REQ-018 FSM states: IDLE, PRECOMP, EMIT, FIN.
REQ-019 IDLE transitions: start with mode=0 -> EMIT with reg = K_0, idx = 0; start with mode=1 -> PRECOMP with reg = K_0, idx = 0.
REQ-020 PRECOMP: each cycle applies F with c = idx+1 and increments idx; after ROUNDS cycles reg = K_ROUNDS and idx = ROUNDS, then go to EMIT; rk_valid stays low throughout.
REQ-021 EMIT: rk_valid is high; on each transfer:
- encrypt: reg <= F(reg, idx+1), idx++;
- decrypt: reg <= G(reg, idx), idx--.
REQ-022 Last transfer (encrypt at idx = ROUNDS, decrypt at idx = 0) -> FIN with no register update.
REQ-023 FIN asserts done for one cycle, then goes to IDLE.
REQ-024 Latency from the start cycle to the first rk_valid:
- encrypt: 1 cycle;
- decrypt: ROUNDS+1 cycles.
REQ-025 While rk_valid is high and rk_ready is low, rk and rk_idx SHALL hold stable.
REQ-026 After a transfer, the next key is presented in the following cycle; full throughput is one key per cycle.
REQ-027 A start asserted while busy SHALL be ignored; mode and key_in are ignored outside the start-in-IDLE cycle.
REQ-028 Round-constant arithmetic is modulo 2^RC_W; idx never wraps for legal ROUNDS.

Reset
REQ-029 rst SHALL force IDLE, with busy = 0, rk_valid = 0, done = 0, rk = 0, rk_idx = 0 and key register = 0.
REQ-030 rst asserted mid-schedule, in any state, SHALL abort the schedule with no done pulse; rst has priority over start.

Structure
REQ-031 A shared package boron_pkg SHALL hold:
- the S-box table {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6} and its inverse;
- the rotation amount (13);
- RC_W;
- the FSM state enumeration.
REQ-032 One combinational sub-module boron_ks_round SHALL implement both F and G, selected by a direction input and parametrised by KEY_W; it is instantiated once.

Verification
REQ-033 KEY_W=80, mode=0, key_in=0, rk_ready=1 -> rk idx0 = 0x0000000000000000, idx1 = 0x080000000000000E; done pulses after idx 25.
REQ-034 Same key with mode=1 -> first rk_valid 26 cycles after start; the 26 keys equal the REQ-033 sequence in reverse; the last key has idx 0 and value 0.
REQ-035 Random key, rk_ready toggled pseudo-randomly -> rk and rk_idx stable while stalled; no key dropped or duplicated.
REQ-036 KEY_W=128, ROUNDS=25, random keys -> decrypt order is the exact reverse of encrypt order; G(F(K,c),c) = K on every step.
REQ-037 rst pulsed during PRECOMP and again during EMIT at idx 7 -> IDLE and all-zero outputs the next cycle, no done pulse; a fresh start then behaves per REQ-033.
REQ-038 start held high across a whole schedule -> exactly one schedule runs; a new schedule begins only at the first start sampled in IDLE after FIN.
